// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU between a CPU port (0) and an NN-engine port (1).
// Round-robin grant under contention; a single registered result slot with per-port response handshake.
module alu_arbiter #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ovfl,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovfl
);

    logic full;
    logic owner;
    logic last_grant;
    logic drain;
    logic slot_free;
    logic grant0;
    logic grant1;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        drain     = full && (owner ? rsp1_ready : rsp0_ready);
        slot_free = !full || drain;
        // Readies are gated by rst so they drop the instant reset asserts, not at the next edge.
        if (!rst && slot_free) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (grant0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full       <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_data   <= '0;
            rsp_ovfl   <= 1'b0;
        end else if (grant0 || grant1) begin
            // Covers the same-cycle drain+accept case: slot reloads and stays full.
            full       <= 1'b1;
            owner      <= grant1;
            last_grant <= grant1;
            rsp_data   <= alu_out;
            rsp_ovfl   <= alu_ovfl;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    assign rsp0_valid = full && !owner;
    assign rsp1_valid = full && owner;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, operand/result width.
REQ-002 Parameter: CTRL_W, 5, ALU opcode width.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  port N (0 = CPU, 1 = NN engine) presents an operation.
REQ-006 req0_ready / req1_ready  output  1  port N operation accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  DATA_W  signed operands.
REQ-008 req0_ctrl / req1_ctrl  input  CTRL_W  ALU opcode.
REQ-009 alu_a, alu_b  output  DATA_W  operands to the shared ALU.
REQ-010 alu_ctrl  output  CTRL_W  opcode to the shared ALU.
REQ-011 alu_out  input  DATA_W  combinational ALU result.
REQ-012 alu_ovfl  input  1  combinational ALU overflow.
REQ-013 rsp0_valid / rsp1_valid  output  1  result held for port N.
REQ-014 rsp0_ready / rsp1_ready  input  1  port N consumes its result.
REQ-015 rsp_data  output  DATA_W  registered result, shared by both ports.
REQ-016 rsp_ovfl  output  1  registered overflow, shared by both ports.

Function
REQ-017 The ALU SHALL be combinational and SHALL be driven only by the granted port; alu_a, alu_b and alu_ctrl SHALL be 0 when no grant is issued.
REQ-018 Handshake: an op transfers on a cycle where reqN_valid && reqN_ready; a requester SHALL hold its valid and operands stable until ready.
REQ-019 Output slot: one result register (data, ovfl, owner bit, full flag); slot is "free" when empty or when the current owner's rspN_valid && rspN_ready this cycle.
REQ-020 Grant SHALL be issued only when the slot is free; at most one reqN_ready SHALL be high per cycle.
REQ-021 Arbitration: one requester valid -> it wins; both valid -> round-robin against last_grant (winner = port not granted last time).
REQ-022 last_grant SHALL update only on an accepted transfer.
REQ-023 On transfer, alu_out and alu_ovfl SHALL be captured into the slot with owner = granted port; rspN_valid for that port SHALL rise the next cycle (latency 1 cycle from accept to response).
REQ-024 rspN_valid = full && owner==N; the other port's rsp_valid SHALL stay 0.
REQ-025 Slot contents SHALL hold unchanged while full and not consumed (response backpressure).
REQ-026 Same-cycle drain and accept SHALL both occur: the slot reloads with the new result and stays full, with no bubble (one op per cycle sustained).
REQ-027 Drain without accept SHALL clear full; rsp_data and rsp_ovfl keep the last value.
REQ-028 Opcodes unsupported by the ALU SHALL pass through unmodified; the arbiter SHALL return whatever the ALU produces (0 for undefined codes).
REQ-029 reqN_ready SHALL be combinational from valids, slot state and last_grant; no combinational path from rsp_data to any ready.

Reset
REQ-030 While rst is high: req0_ready=req1_ready=0, rsp0_valid=rsp1_valid=0, rsp_data=0, rsp_ovfl=0, full=0, owner=0, last_grant=1 (port 0 wins the first contention).
REQ-031 Reset asserted mid-operation SHALL discard any held result without a response; requesters re-present after reset.
REQ-032 First grant SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-033 Single op: port 0 issues a=0x0003, b=0x0004, ctrl=0x00 -> req0_ready same cycle; next cycle rsp0_valid=1, rsp_data=0x0007, rsp_ovfl=0, rsp1_valid=0.
REQ-034 Overflow: port 1 issues a=0x7FFF, b=0x0001, ctrl=0x00 -> rsp1_valid=1, rsp_data=0x8000, rsp_ovfl=1.
REQ-035 Contention: both valid continuously from reset, rsp ready tied 1 -> grants 0,1,0,1,...; one result per cycle; owners alternate.
REQ-036 Backpressure: port 0 result held with rsp0_ready=0 for 3 cycles while port 1 is valid -> req1_ready=0 for those cycles, rsp_data stable; grant to port 1 in the cycle rsp0_ready rises.
REQ-037 Reset mid-op: slot full, rsp0_valid=1, assert rst asynchronously between edges -> rsp0_valid and all readies drop immediately; after release, first contention goes to port 0.
REQ-038 Undefined opcode 0x1F from port 1 -> rsp_data=0x0000, rsp_ovfl=0.
